// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the EX-stage divide control unit.
package div_ctrl_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] FN_DIV  = 3'b100;
   localparam logic [2:0] FN_DIVU = 3'b101;
   localparam logic [2:0] FN_REM  = 3'b110;
   localparam logic [2:0] FN_REMU = 3'b111;

   localparam logic [WIDTH_DEF-1:0] INT_MIN  = {1'b1, {(WIDTH_DEF-1){1'b0}}};
   localparam logic [WIDTH_DEF-1:0] ALL_ONES = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BUSY,
      ST_RESP,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/div_special_det.sv
// Detects ops that can be answered without the divider (div-by-zero, signed
// overflow, last-result reuse) and muxes the corresponding result.
module div_special_det
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic             sign,
   input  logic             sel_rem,
   input  logic             cache_vld,
   input  logic [WIDTH-1:0] cache_rs1,
   input  logic [WIDTH-1:0] cache_rs2,
   input  logic             cache_sign,
   input  logic [WIDTH-1:0] cache_quo,
   input  logic [WIDTH-1:0] cache_rem,
   output logic             take,
   output logic [WIDTH-1:0] res
);

   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   logic div_zero;
   logic overflow;
   logic cache_hit;

   assign div_zero  = (rs2 == '0);
   assign overflow  = sign && (rs1 == MIN) && (rs2 == ONES);
   assign cache_hit = CACHE_EN && cache_vld && (rs1 == cache_rs1) &&
                      (rs2 == cache_rs2) && (sign == cache_sign);
   assign take      = div_zero | overflow | cache_hit;

   // Divide-by-zero outranks overflow (rs2 cannot be both zero and all ones).
   always_comb begin
      res = '0;
      if (div_zero)
         res = sel_rem ? rs1 : ONES;
      else if (overflow)
         res = sel_rem ? '0 : MIN;
      else if (cache_hit)
         res = sel_rem ? cache_rem : cache_quo;
   end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage control for DIV/DIVU/REM/REMU: drives the iterative divider,
// resolves special cases and reuses the last divider result when possible.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_funct3,
   input  logic [WIDTH-1:0] op_rs1,
   input  logic [WIDTH-1:0] op_rs2,
   input  logic             flush,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   output logic             div_sign,
   output logic             div_start,
   input  logic             div_busy,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder
);

   state_t state, state_nx;

   logic             accept;
   logic             sel_rem;
   logic             busy_seen;
   logic             div_done;
   logic             sp_take;
   logic [WIDTH-1:0] sp_res;

   logic             c_vld;
   logic             c_sign;
   logic [WIDTH-1:0] c_rs1, c_rs2, c_quo, c_rem;

   assign accept   = op_valid && op_ready && op_funct3[2];
   assign div_done = (state == ST_BUSY) && !flush && !div_busy;

   div_special_det #(
      .WIDTH    (WIDTH),
      .CACHE_EN (CACHE_EN)
   ) u_det (
      .rs1        (op_rs1),
      .rs2        (op_rs2),
      .sign       (~op_funct3[0]),
      .sel_rem    (op_funct3[1]),
      .cache_vld  (c_vld),
      .cache_rs1  (c_rs1),
      .cache_rs2  (c_rs2),
      .cache_sign (c_sign),
      .cache_quo  (c_quo),
      .cache_rem  (c_rem),
      .take       (sp_take),
      .res        (sp_res)
   );

   always_comb begin
      state_nx  = state;
      op_ready  = (state == ST_IDLE) && !flush && rst_n;
      res_valid = (state == ST_RESP) && !flush;
      div_start = (state == ST_START) || (state == ST_BUSY) || (state == ST_DRAIN);
      case (state)
         ST_IDLE:  if (accept) state_nx = sp_take ? ST_RESP : ST_START;
         ST_START: begin
            if (flush)         state_nx = ST_DRAIN;
            else if (div_busy) state_nx = ST_BUSY;
         end
         ST_BUSY: begin
            if (flush)          state_nx = ST_DRAIN;
            else if (!div_busy) state_nx = ST_RESP;
         end
         ST_RESP:  state_nx = ST_IDLE;
         // The handshake must finish: hold start until busy has risen and fallen.
         ST_DRAIN: if (busy_seen && !div_busy) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         res_data     <= '0;
         div_dividend <= '0;
         div_divisor  <= '0;
         div_sign     <= 1'b0;
         sel_rem      <= 1'b0;
         busy_seen    <= 1'b0;
         c_vld        <= 1'b0;
         c_sign       <= 1'b0;
         c_rs1        <= '0;
         c_rs2        <= '0;
         c_quo        <= '0;
         c_rem        <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            div_dividend <= op_rs1;
            div_divisor  <= op_rs2;
            div_sign     <= ~op_funct3[0];
            sel_rem      <= op_funct3[1];
            if (sp_take) res_data <= sp_res;
         end
         if (div_done) begin
            res_data <= sel_rem ? div_remainder : div_quotient;
            if (CACHE_EN) begin
               c_vld  <= 1'b1;
               c_sign <= div_sign;
               c_rs1  <= div_dividend;
               c_rs2  <= div_divisor;
               c_quo  <= div_quotient;
               c_rem  <= div_remainder;
            end
         end
         // A flush from BUSY means busy already rose; from START it may rise now.
         if (state_nx == ST_DRAIN && state != ST_DRAIN) begin
            busy_seen <= (state == ST_BUSY) || div_busy;
            c_vld     <= 1'b0;
         end else if (state == ST_DRAIN) begin
            busy_seen <= busy_seen || div_busy;
         end
      end
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
EX-stage control unit for the M-extension divide ops (DIV/DIVU/REM/REMU); it sits between the pipeline's execute stage and the iterative divider.
- Decodes funct3 and drives the divider's operand, sign and start inputs.
- Waits on busy, then selects quotient or remainder.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Short-circuits a REM/DIV that follows a DIV/REM with identical operands and signedness.

Parameters:
WIDTH, 32, operand/result width
CACHE_EN, 1, 1 = enable last-result reuse; 0 = every op uses the divider

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  divide op present in EX
op_ready  out  1  op accepted this cycle when op_valid & op_ready
op_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU (bit2 must be 1; other codes ignored)
op_rs1  in  WIDTH  dividend
op_rs2  in  WIDTH  divisor
flush  in  1  kill in-flight op
res_valid  out  1  one-cycle pulse, result valid
res_data  out  WIDTH  quotient or remainder
div_dividend  out  WIDTH  to divider
div_divisor  out  WIDTH  to divider
div_sign  out  1  to divider, 1 = signed
div_start  out  1  to divider
div_busy  in  1  from divider
div_quotient  in  WIDTH  from divider
div_remainder  in  WIDTH  from divider

Behaviour:
Reset (async, rst_n=0):
- All outputs 0; state IDLE; cache invalid.

Acceptance and capture:
- op_ready = 1 only in IDLE with flush=0.
- On accept, capture operands, sign = ~funct3[0], sel_rem = funct3[1].
- div_* operand/sign outputs are registered copies, stable for the whole operation.

States:
- IDLE → on accept: to RESP if special case or cache hit, else to START.
- START: div_start=1; wait for div_busy=1 → BUSY.
- BUSY: hold div_start=1 until div_busy=0. Latch quotient and remainder into the cache (operands, sign, cache valid=1). Load res_data → RESP.
- RESP: res_valid=1 for exactly one cycle, div_start=0 → IDLE.
- DRAIN: entered on flush in START or BUSY. Keep div_start=1 until div_busy has risen and then fallen; discard the result; invalidate the cache → IDLE. No res_valid.

Flush:
- Flush in RESP suppresses res_valid and goes to IDLE; the cache keeps the completed result.
- Flush in IDLE blocks acceptance that cycle.
- The divider protocol is never truncated: div_start is only dropped after busy falls.

Special cases (registered, result one cycle after accept, divider untouched):
- Divisor == 0: quotient = all ones; remainder = rs1 (both signednesses).
- Signed, rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

Cache hit (CACHE_EN=1):
- Condition: cache valid, operands equal, sign equal.
- Result one cycle after accept.

Latency:
- Normal path: res_valid in the cycle after div_busy is seen low in BUSY.
- Back-to-back: the next op can be accepted the cycle after RESP.

Sign:
- Quotient truncates toward zero; remainder takes the sign of the dividend. The divider supplies this behaviour.

Decomposition:
- Shared package: funct3 encodings (FN_DIV, FN_DIVU, FN_REM, FN_REMU), state encoding, WIDTH default, special-case constants (INT_MIN, all-ones).
- One natural sub-module: div_special_det (combinational detection of divide-by-zero, overflow and cache hit, plus the special-case result mux).
- The FSM stays in div_ctrl, which instantiates nothing else. The divider is instantiated beside it at EX level.

Test Plan:
- DIVU rs1=0xFFFFFEA3, rs2=26 → div_sign=0, one start/busy handshake, res_data=0x09D89D7C; then REMU with the same operands → 0x0000000B via cache hit, no second div_start.
- DIV rs1=0xFFFFFEA3 (−349), rs2=26 → res_data=0xFFFFFFF3 (−13); following REM → 0xFFFFFFF5 (−11) via cache hit one cycle after accept.
- DIV 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; each has res_valid one cycle after accept and div_start never asserted.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0; DIVU with the same operands goes to the divider and yields 0.
- Flush asserted two cycles into BUSY → no res_valid; div_start held until busy falls; op_ready stays 0 through DRAIN; the next identical op misses the cache and restarts the divider.
- rst_n pulsed low mid-BUSY → all outputs 0 asynchronously and cache invalid; a new op after reset completes correctly.
